// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

    // Fetch FSM: IDLE looks up the cache, FETCH refills one word byte by byte.
    typedef enum logic {
        IF_IDLE  = 1'b0,
        IF_FETCH = 1'b1
    } fetch_state_t;

    localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;
    localparam logic [2:0]  BYTES_PER_WORD = 3'd4;
    localparam logic [1:0]  LAST_BYTE      = 2'd3;

endpackage

// File: rtl/if_fetch_icache.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// Lookup is combinational; refill writes happen at the clock edge.
module if_fetch_icache
    import if_fetch_pkg::*;
#(
    parameter int LINES = 64,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    input  logic [TAG_W-1:0] i_rd_tag,
    output logic             o_hit,
    output logic [31:0]      o_rdata,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  logic [31:0]      i_wdata
);

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES];

    // Valid bits: cleared by reset, set when a refill lands in a line.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // Tag and data arrays: written only by a completed refill.
    // NOTE: the arrays are deliberately not reset; a line cannot hit until its valid bit is set.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wdata;
        end
    end

    assign o_hit   = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
    assign o_rdata = r_data[i_rd_idx];

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: holds the PC, looks it up in the icache and on a
// miss assembles the word from four byte reads through the memory arbiter.
// Accepts redirects from ID and raises stall_req while no word is ready.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int ADDR_W       = 17,
    parameter int ICACHE_LINES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [4:0]  stall,
    input  logic        use_npc,
    input  logic [31:0] npc_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_grant,
    input  logic [7:0]  mem_din,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stall_req
);

    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    logic [31:0]      r_pc;
    logic [2:0]       r_iss;     // bytes requested and granted so far
    logic [1:0]       r_rcv;     // bytes captured so far
    logic [23:0]      r_word;    // low three bytes of the word being assembled
    logic             r_pend;    // a granted byte is on mem_din this cycle

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic [31:0]      w_line_data;
    logic             w_req;
    logic             w_complete;
    logic             w_word_ok;
    logic             w_redirect;
    logic             w_advance;
    logic             w_issue;
    logic             w_fill;
    logic [31:0]      w_word_full;
    logic             w_unused_stall;

    assign w_idx = r_pc[2+IDX_W-1:2];
    assign w_tag = r_pc[ADDR_W-1:2+IDX_W];

    if_fetch_icache #(
        .LINES (ICACHE_LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_icache (
        .clk      (clk),
        .rst      (rst),
        .i_rd_idx (w_idx),
        .i_rd_tag (w_tag),
        .o_hit    (w_hit),
        .o_rdata  (w_line_data),
        .i_we     (w_fill),
        .i_wr_idx (w_idx),
        .i_wr_tag (w_tag),
        .i_wdata  (w_word_full)
    );

    // Only ID's stall bit matters to this stage.
    assign w_unused_stall = ^{stall[4:2], stall[0]};

    assign w_redirect  = use_npc && !stall[1];
    assign w_word_full = {mem_din, r_word};

    // Fetch FSM state register; rdy low freezes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IF_IDLE;
        end else if (rdy) begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, byte request and word-ready decode.
    // NOTE: every always_comb output is defaulted first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_complete  = 1'b0;
        w_word_ok   = 1'b0;
        case (r_state)
            IF_IDLE: begin
                // A miss issues byte 0 immediately so the cold fetch takes 5 cycles.
                w_word_ok = w_hit;
                w_req     = !w_hit;
                if (!w_hit) begin
                    w_state_nxt = IF_FETCH;
                end
            end
            IF_FETCH: begin
                w_req      = (r_iss < BYTES_PER_WORD);
                w_complete = r_pend && (r_rcv == LAST_BYTE);
                w_word_ok  = w_complete;
                if (w_complete) begin
                    w_state_nxt = IF_IDLE;
                end
            end
            default: w_state_nxt = IF_IDLE;
        endcase
        if (w_redirect) begin
            w_state_nxt = IF_IDLE;
        end
    end

    assign w_issue   = mem_req && mem_grant;
    assign w_advance = w_word_ok && !stall[1] && !w_redirect;
    assign w_fill    = rdy && !rst && w_complete && !w_redirect;

    assign mem_req   = !rst && rdy && w_req;
    assign mem_addr  = rst ? ZERO_WORD : ({r_pc[31:2], 2'b00} + {29'd0, r_iss});
    assign if_pc     = rst ? ZERO_WORD : r_pc;
    assign if_inst   = rst        ? ZERO_WORD   :
                       w_complete ? w_word_full :
                       w_word_ok  ? w_line_data : ZERO_WORD;
    assign stall_req = !rst && (w_redirect || !w_word_ok);

    // PC, byte counters, partial word and in-flight flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc   <= ZERO_WORD;
            r_iss  <= '0;
            r_rcv  <= '0;
            r_word <= '0;
            r_pend <= 1'b0;
        end else if (rdy) begin
            // A byte granted in a redirect cycle belongs to the wrong path; drop it.
            r_pend <= w_issue && !w_redirect;

            if (w_redirect) begin
                r_pc <= npc_addr;
            end else if (w_advance) begin
                r_pc <= r_pc + 32'd4;
            end

            if (w_redirect || w_complete) begin
                r_iss <= '0;
                r_rcv <= '0;
            end else begin
                if (w_issue) begin
                    r_iss <= r_iss + 3'd1;
                end
                if (r_pend) begin
                    case (r_rcv)
                        2'd0:    r_word[7:0]   <= mem_din;
                        2'd1:    r_word[15:8]  <= mem_din;
                        2'd2:    r_word[23:16] <= mem_din;
                        default: ;
                    endcase
                    r_rcv <= r_rcv + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: cold fetch, grant gaps, redirects, cache hits,
// ID stall and rdy freeze, against a byte-wide memory responder.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [4:0]  stall;
    logic        use_npc;
    logic [31:0] npc_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_grant;
    logic [7:0]  mem_din;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stall_req;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0]  mem [0:511];
    logic [31:0] exp_w [3];

    always #5 clk = ~clk;

    if_fetch #(
        .ADDR_W       (17),
        .ICACHE_LINES (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .stall     (stall),
        .use_npc   (use_npc),
        .npc_addr  (npc_addr),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_grant (mem_grant),
        .mem_din   (mem_din),
        .if_pc     (if_pc),
        .if_inst   (if_inst),
        .stall_req (stall_req)
    );

    // Memory responder: a granted byte appears on mem_din the next cycle,
    // and nothing moves while rdy is low.
    always @(posedge clk) begin
        if (rdy && mem_req && mem_grant) begin
            mem_din <= mem[mem_addr[8:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic put_word(input int a, input logic [31:0] w);
        mem[a]     = w[7:0];
        mem[a + 1] = w[15:8];
        mem[a + 2] = w[23:16];
        mem[a + 3] = w[31:24];
    endtask

    // Step until a valid word is presented, bounded by a cycle budget.
    task automatic wait_word(input string tag);
        int n = 0;
        while (stall_req !== 1'b0 && n < 12) begin
            cyc();
            settle();
            n++;
        end
        check(tag, 32'(stall_req), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        put_word(32'h000, 32'h0010_0513);
        put_word(32'h004, 32'h0020_0593);
        put_word(32'h008, 32'hFF9F_F06F);
        put_word(32'h00C, 32'hDEAD_BEEF);
        put_word(32'h100, 32'h1234_5678);
        put_word(32'h104, 32'hCAFE_BABE);
        exp_w[0] = 32'h0010_0513;
        exp_w[1] = 32'h0020_0593;
        exp_w[2] = 32'hFF9F_F06F;

        rst       = 1'b1;
        rdy       = 1'b1;
        stall     = 5'b00000;
        use_npc   = 1'b0;
        npc_addr  = 32'h0;
        mem_grant = 1'b1;

        // ---- 1: reset state, then cold fetch at 0 with continuous grant
        cyc(); cyc(); settle();
        check("rst_mem_req",   32'(mem_req),   32'd0);
        check("rst_mem_addr",  mem_addr,       32'd0);
        check("rst_if_pc",     if_pc,          32'd0);
        check("rst_if_inst",   if_inst,        32'd0);
        check("rst_stall_req", 32'(stall_req), 32'd0);
        rst = 1'b0;
        settle();
        check("t1_req0",   32'(mem_req),   32'd1);
        check("t1_addr0",  mem_addr,       32'd0);
        check("t1_stall0", 32'(stall_req), 32'd1);
        for (int i = 1; i < 4; i++) begin
            cyc(); settle();
            check("t1_addr",  mem_addr,       32'(i));
            check("t1_stall", 32'(stall_req), 32'd1);
        end
        cyc(); settle();
        check("t1_done_stall", 32'(stall_req), 32'd0);
        check("t1_done_inst",  if_inst,        32'h0010_0513);
        check("t1_done_pc",    if_pc,          32'd0);
        cyc(); settle();
        check("t1_pc_adv",     if_pc,          32'd4);

        // ---- 2: grant dropped for two cycles after byte 1 issued
        check("t2_addr4", mem_addr, 32'd4);
        cyc(); settle();
        check("t2_addr5", mem_addr, 32'd5);
        cyc(); mem_grant = 1'b0; settle();
        check("t2_hold_a",  mem_addr,       32'd6);
        check("t2_stall_a", 32'(stall_req), 32'd1);
        cyc(); settle();
        check("t2_hold_b",  mem_addr,       32'd6);
        cyc(); mem_grant = 1'b1; settle();
        check("t2_hold_c",  mem_addr,       32'd6);
        cyc(); settle();
        check("t2_addr7",   mem_addr,       32'd7);
        check("t2_stall_d", 32'(stall_req), 32'd1);
        cyc(); settle();
        check("t2_done_stall", 32'(stall_req), 32'd0);
        check("t2_done_inst",  if_inst,        32'h0020_0593);
        check("t2_done_pc",    if_pc,          32'd4);

        // ---- 3: redirect to 0x100 while byte 2 of line 0 is in flight
        cyc(); rst = 1'b1;
        cyc(); settle();
        check("rst2_mem_req", 32'(mem_req), 32'd0);
        check("rst2_if_pc",   if_pc,        32'd0);
        rst = 1'b0;
        settle();
        check("t3_addr0", mem_addr, 32'd0);
        cyc(); settle();
        cyc(); use_npc = 1'b1; npc_addr = 32'h100; settle();
        check("t3_redir_stall", 32'(stall_req), 32'd1);
        cyc(); use_npc = 1'b0; settle();
        check("t3_new_pc",   if_pc,         32'h100);
        check("t3_new_addr", mem_addr,      32'h100);
        check("t3_new_req",  32'(mem_req),  32'd1);
        wait_word("t3_wait");
        check("t3_inst", if_inst, 32'h1234_5678);
        check("t3_pc",   if_pc,   32'h100);
        cyc(); use_npc = 1'b1; npc_addr = 32'h0; settle();
        check("t3_redir0_stall", 32'(stall_req), 32'd1);
        cyc(); use_npc = 1'b0; settle();
        check("t3_line0_pc",   if_pc,          32'd0);
        check("t3_line0_miss", 32'(mem_req),   32'd1);
        check("t3_line0_stl",  32'(stall_req), 32'd1);

        // ---- 4: first pass 0,4,8 fills the cache; redirect back, second pass all hits
        wait_word("t4_w0_wait");
        check("t4_w0_inst", if_inst, exp_w[0]);
        cyc(); settle();
        wait_word("t4_w1_wait");
        check("t4_w1_inst", if_inst, exp_w[1]);
        check("t4_w1_pc",   if_pc,   32'd4);
        cyc(); settle();
        wait_word("t4_w2_wait");
        check("t4_w2_inst", if_inst, exp_w[2]);
        check("t4_w2_pc",   if_pc,   32'd8);
        cyc(); use_npc = 1'b1; npc_addr = 32'h0; settle();
        check("t4_loop_pc",    if_pc,          32'd12);
        check("t4_loop_stall", 32'(stall_req), 32'd1);
        for (int k = 0; k < 3; k++) begin
            cyc(); use_npc = 1'b0; settle();
            check("t4_hit_stall", 32'(stall_req), 32'd0);
            check("t4_hit_req",   32'(mem_req),   32'd0);
            check("t4_hit_inst",  if_inst,        exp_w[k]);
            check("t4_hit_pc",    if_pc,          32'(4 * k));
        end

        // ---- 5: ID stalled for 3 cycles on a hit; a redirect under stall is ignored
        stall = 5'b00010;
        cyc(); use_npc = 1'b1; npc_addr = 32'h200; settle();
        check("t5_hold_pc_a",  if_pc,          32'd8);
        check("t5_hold_inst",  if_inst,        exp_w[2]);
        check("t5_npc_ignore", 32'(stall_req), 32'd0);
        cyc(); use_npc = 1'b0; settle();
        check("t5_hold_pc_b",  if_pc,          32'd8);
        check("t5_hold_inst_b", if_inst,       exp_w[2]);
        cyc(); stall = 5'b00000; settle();
        check("t5_hold_pc_c",  if_pc,          32'd8);
        cyc(); settle();
        check("t5_adv_pc",     if_pc,          32'd12);
        check("t5_adv_addr",   mem_addr,       32'd12);

        // ---- 6: rdy low for 3 cycles in the middle of a refill
        cyc(); settle();
        check("t6_addr13", mem_addr, 32'd13);
        cyc(); rdy = 1'b0;
        repeat (3) begin
            settle();
            check("t6_frz_req",  32'(mem_req), 32'd0);
            check("t6_frz_addr", mem_addr,     32'd14);
            check("t6_frz_pc",   if_pc,        32'd12);
            cyc();
        end
        rdy = 1'b1;
        settle();
        check("t6_res_req",  32'(mem_req), 32'd1);
        check("t6_res_addr", mem_addr,     32'd14);
        cyc(); settle();
        check("t6_addr15",   mem_addr,     32'd15);
        cyc(); settle();
        check("t6_done_stall", 32'(stall_req), 32'd0);
        check("t6_done_inst",  if_inst,        32'hDEAD_BEEF);
        check("t6_done_pc",    if_pc,          32'd12);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
